syscall_unit: RTL and testbench

//  Services the syscall request raised by the instruction decoder (syscall strobe with $v0/$a0 values).

---
 rtl/syscall_unit.sv | 154 +++++++++++++++
 tb/tb_syscall_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// Syscall service unit: stalls the core while it runs print_int, print_char,
// puts (NUL-terminated string read from data memory) or exit.
module syscall_unit #(
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] vreg,
    input  logic [31:0] areg,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        halt,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        int_valid,
    output logic [31:0] int_data,
    input  logic        int_ready
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_LEN);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INT   = 3'd1;
    localparam logic [2:0] CHAR  = 3'd2;
    localparam logic [2:0] FETCH = 3'd3;
    localparam logic [2:0] EMIT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]    state;
    logic [31:0]   arg_q;
    logic [31:0]   addr_q;
    logic [31:0]   word_q;
    logic [CW-1:0] count_q;
    logic          syscall_q;
    logic          seen_low;
    logic          start_cond;
    logic [7:0]    cur_byte;
    logic [31:0]   next_addr;
    logic [CW-1:0] next_count;

    // seen_low keeps a syscall level held across reset release from starting a service.
    assign start_cond = (state == IDLE) & syscall & ~syscall_q & seen_low & ~halt;
    assign stall      = ~halt & (start_cond | (state != IDLE));
    assign next_addr  = addr_q + 32'd1;
    assign next_count = count_q + 1'b1;

    // Strings are packed big-endian within each memory word.
    always_comb begin
        cur_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: cur_byte = word_q[31:24];
            2'd1: cur_byte = word_q[23:16];
            2'd2: cur_byte = word_q[15:8];
            2'd3: cur_byte = word_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    assign done       = (state == DONE);
    assign mem_rd     = (state == FETCH);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign int_valid  = (state == INT);
    assign int_data   = arg_q;
    assign char_valid = (state == CHAR) | ((state == EMIT) & (cur_byte != 8'h00));
    assign char_data  = (state == CHAR) ? arg_q[7:0] : cur_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            arg_q     <= 32'd0;
            addr_q    <= 32'd0;
            word_q    <= 32'd0;
            count_q   <= '0;
            syscall_q <= 1'b0;
            seen_low  <= 1'b0;
            err       <= 1'b0;
            halt      <= 1'b0;
        end else begin
            syscall_q <= syscall;
            if (!syscall) begin
                seen_low <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_cond) begin
                        arg_q   <= areg;
                        addr_q  <= areg;
                        count_q <= '0;
                        err     <= 1'b0;
                        case (vreg)
                            32'd1:   state <= INT;
                            32'd4:   state <= FETCH;
                            32'd11:  state <= CHAR;
                            32'd10: begin
                                state <= DONE;
                                halt  <= 1'b1;
                            end
                            default: begin
                                state <= DONE;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                INT: begin
                    if (int_ready) begin
                        state <= DONE;
                    end
                end
                CHAR: begin
                    if (char_ready) begin
                        state <= DONE;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        word_q <= mem_rdata;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (cur_byte == 8'h00) begin
                        state <= DONE;
                    end else if (char_ready) begin
                        addr_q  <= next_addr;
                        count_q <= next_count;
                        // Truncation wins over a word boundary on the same byte.
                        if (next_count == MAX_COUNT) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end else if (next_addr[1:0] == 2'b00) begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: directed services against a memory model
// and a console sink with programmable handshake delays.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall;
    logic [31:0] vreg;
    logic [31:0] areg;
    logic        stall;
    logic        done;
    logic        err;
    logic        halt;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        int_valid;
    logic [31:0] int_data;
    logic        int_ready;

    int total = 0;
    int bad = 0;

    int char_delay = 0;
    int mem_delay = 0;
    logic [31:0] mem [logic [31:0]];

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        e;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] rd_q[$];

    syscall_unit #(.MAX_LEN(4)) dut (
        .clk(clk), .reset(reset), .syscall(syscall), .vreg(vreg), .areg(areg),
        .stall(stall), .done(done), .err(err), .halt(halt),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .int_valid(int_valid), .int_data(int_data), .int_ready(int_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] data, input logic e);
        ev_t ev;
        ev.kind = kind;
        ev.data = data;
        ev.e    = e;
        exp_q.push_back(ev);
    endtask

    task automatic pop_check(input int kind, input logic [31:0] data, input logic e);
        ev_t ev;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=kind%0d/%h required=none", kind, data);
        end else begin
            ev = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(ev.kind));
            if (kind == 2) check("done_err", {31'd0, e}, {31'd0, ev.e});
            else check("event_data", data, ev.data);
        end
    endtask

    // Memory responder: raises mem_ready after mem_delay cycles of mem_rd.
    initial begin
        int cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_rd) begin
                if (cnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Character sink: raises char_ready after char_delay cycles of char_valid.
    initial begin
        int cnt = 0;
        char_ready = 1'b0;
        int_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (char_ready) begin
                char_ready = 1'b0;
                cnt = 0;
            end else if (char_valid) begin
                if (cnt >= char_delay) char_ready = 1'b1;
                else cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks held payloads.
    logic        cv_wait = 1'b0;
    logic [7:0]  cd_prev = 8'd0;
    logic        rd_wait = 1'b0;
    logic [31:0] ra_prev = 32'd0;
    always @(negedge clk) begin
        if (reset) begin
            cv_wait = 1'b0;
            rd_wait = 1'b0;
        end else begin
            if (cv_wait) begin
                check("char_valid_held", {31'd0, char_valid}, 32'd1);
                check("char_data_held", {24'd0, char_data}, {24'd0, cd_prev});
            end
            if (rd_wait) begin
                check("mem_rd_held", {31'd0, mem_rd}, 32'd1);
                check("mem_addr_held", mem_addr, ra_prev);
            end
            if (char_valid && char_ready) pop_check(0, {24'd0, char_data}, 1'b0);
            if (int_valid && int_ready) pop_check(1, int_data, 1'b0);
            if (done) pop_check(2, 32'd0, err);
            if (mem_rd && mem_ready) begin
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read actual=%h required=none", mem_addr);
                end else begin
                    check("read_addr", mem_addr, rd_q.pop_front());
                end
            end
            cv_wait = char_valid & ~char_ready;
            cd_prev = char_data;
            rd_wait = mem_rd & ~mem_ready;
            ra_prev = mem_addr;
        end
    end

    task automatic applyStimulus(input logic [31:0] code, input logic [31:0] arg);
        int n = 0;
        @(posedge clk);
        #1;
        vreg = code;
        areg = arg;
        syscall = 1'b1;
        #1;
        check("stall_at_start", {31'd0, stall}, 32'd1);
        forever begin
            @(negedge clk);
            if (done) break;
            check("stall_busy", {31'd0, stall}, 32'd1);
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL done_timeout actual=no_done required=done");
                break;
            end
        end
        @(posedge clk);
        #1;
        syscall = 1'b0;
        check("stall_after_done", {31'd0, stall}, 32'd0);
    endtask

    task automatic checkOutput(input string name);
        check({name, "_events_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_reads_left"}, 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        syscall = 1'b0;
        vreg = 32'd0;
        areg = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {stall, done, err, halt, mem_rd, char_valid, int_valid, char_data},
              32'd0);
        check("reset_addr_int", mem_addr | int_data, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] puts aligned");
        mem[32'h100] = 32'h48690000;
        rd_q.push_back(32'h100);
        push_ev(0, 32'h48, 1'b0);
        push_ev(0, 32'h69, 1'b0);
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd4, 32'h100);
        checkOutput("puts1");

        $display("[TB] puts unaligned spanning words");
        mem[32'h100] = 32'h00000041;
        mem[32'h104] = 32'h42000000;
        rd_q.push_back(32'h100);
        rd_q.push_back(32'h104);
        push_ev(0, 32'h41, 1'b0);
        push_ev(0, 32'h42, 1'b0);
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd4, 32'h103);
        checkOutput("puts2");

        $display("[TB] puts with backpressure");
        char_delay = 5;
        mem_delay = 3;
        rd_q.push_back(32'h100);
        rd_q.push_back(32'h104);
        push_ev(0, 32'h41, 1'b0);
        push_ev(0, 32'h42, 1'b0);
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd4, 32'h103);
        checkOutput("puts3");
        char_delay = 0;
        mem_delay = 0;

        $display("[TB] print_int, print_char, bad code");
        push_ev(1, 32'hFFFFFFF6, 1'b0);
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd1, 32'hFFFFFFF6);
        push_ev(0, 32'h41, 1'b0);
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd11, 32'h141);
        push_ev(2, 32'd0, 1'b1);
        applyStimulus(32'd7, 32'h0);
        check("err_sticky", {31'd0, err}, 32'd1);
        checkOutput("misc");

        $display("[TB] puts truncation");
        mem[32'h200] = 32'h41424344;
        mem[32'h204] = 32'h45464748;
        rd_q.push_back(32'h200);
        push_ev(0, 32'h41, 1'b0);
        push_ev(0, 32'h42, 1'b0);
        push_ev(0, 32'h43, 1'b0);
        push_ev(0, 32'h44, 1'b0);
        push_ev(2, 32'd0, 1'b1);
        applyStimulus(32'd4, 32'h200);
        checkOutput("trunc");

        $display("[TB] exit and ignored syscall");
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd10, 32'h0);
        check("halt_set", {31'd0, halt}, 32'd1);
        @(posedge clk);
        #1;
        vreg = 32'd11;
        areg = 32'h55;
        syscall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("halted_stall", {31'd0, stall}, 32'd0);
            check("halted_done", {31'd0, done}, 32'd0);
        end
        syscall = 1'b0;
        checkOutput("halted");

        $display("[TB] reset during emit wait");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem[32'h100] = 32'h48690000;
        char_delay = 50;
        rd_q.push_back(32'h100);
        @(posedge clk);
        #1;
        vreg = 32'd4;
        areg = 32'h100;
        syscall = 1'b1;
        n = 0;
        while (!char_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("emit_reached", {31'd0, char_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {stall, done, err, halt, mem_rd, char_valid, int_valid, char_data},
              32'd0);
        exp_q.delete();
        char_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_syscall_stall", {31'd0, stall}, 32'd0);
            check("held_syscall_cv", {31'd0, char_valid}, 32'd0);
        end
        syscall = 1'b0;
        @(posedge clk);
        push_ev(0, 32'h41, 1'b0);
        push_ev(2, 32'd0, 1'b0);
        applyStimulus(32'd11, 32'h141);
        checkOutput("after_reset");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
